// File: rtl/axis_fifo_rd_if.sv
// Read side of a FWFT-less FIFO turned into an AXI-Stream master.
// A 2-entry skid buffer absorbs the one-cycle read latency so tready can stall freely.
module axis_fifo_rd_if #(
    parameter int unsigned FIFO_WIDTH = 33,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  rd_clk,
    input  logic                  rd_rst,
    input  logic                  fifo_empty,
    input  logic [FIFO_WIDTH-1:0] fifo_rd_data,
    output logic                  fifo_rd_en,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic [FIFO_WIDTH-2:0] m_axis_tdata,
    output logic                  m_axis_tlast,
    output logic [CNT_WIDTH-1:0]  pkt_cnt
);

    typedef enum logic [1:0] {
        OccEmpty = 2'd0,
        OccOne   = 2'd1,
        OccTwo   = 2'd2
    } occ_e;

    occ_e                  r_occ;
    logic                  r_inflight;
    logic [FIFO_WIDTH-1:0] r_head;
    logic [FIFO_WIDTH-1:0] r_tail;
    logic [CNT_WIDTH-1:0]  r_pkt_cnt;

    logic                  w_valid;
    logic                  w_pop;
    logic [1:0]            w_total;

    assign w_valid = (r_occ != OccEmpty) && !rd_rst;
    assign w_pop   = w_valid && m_axis_tready;
    assign w_total = r_occ + {1'b0, r_inflight};

    // A read is only issued if the word it returns is guaranteed a free slot.
    always_comb begin
        fifo_rd_en = 1'b0;
        if (!fifo_empty && !rd_rst) begin
            fifo_rd_en = (w_total < 2'd2) || ((w_total == 2'd2) && w_pop);
        end
    end

    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            r_occ      <= OccEmpty;
            r_inflight <= 1'b0;
            r_head     <= '0;
            r_tail     <= '0;
            r_pkt_cnt  <= '0;
        end else begin
            r_inflight <= fifo_rd_en;
            if (w_pop && r_head[FIFO_WIDTH-1]) begin
                r_pkt_cnt <= r_pkt_cnt + 1'b1;
            end
            unique case (r_occ)
                OccEmpty: begin
                    if (r_inflight) begin
                        r_head <= fifo_rd_data;
                        r_occ  <= OccOne;
                    end
                end
                OccOne: begin
                    case ({r_inflight, w_pop})
                        2'b10: begin
                            r_tail <= fifo_rd_data;
                            r_occ  <= OccTwo;
                        end
                        2'b11:   r_head <= fifo_rd_data;
                        2'b01:   r_occ  <= OccEmpty;
                        default: ;
                    endcase
                end
                OccTwo: begin
                    if (w_pop) begin
                        r_head <= r_tail;
                        if (r_inflight) begin
                            r_tail <= fifo_rd_data;
                        end else begin
                            r_occ <= OccOne;
                        end
                    end
                end
                default: r_occ <= OccEmpty;
            endcase
        end
    end

    // Outputs are masked by reset so they read zero from the first reset cycle.
    assign m_axis_tvalid = w_valid;
    assign m_axis_tdata  = rd_rst ? '0 : r_head[FIFO_WIDTH-2:0];
    assign m_axis_tlast  = rd_rst ? 1'b0 : r_head[FIFO_WIDTH-1];
    assign pkt_cnt       = rd_rst ? '0 : r_pkt_cnt;

endmodule

// File: tb/tb_axis_fifo_rd_if.sv
// Bench for axis_fifo_rd_if: behavioural FIFO model, beat scoreboard, a cycle table for
// the streaming case and hand-written sequences for stall, toggling, wrap and reset.
module tb_axis_fifo_rd_if;

    localparam int FW = 33;
    localparam int CW = 16;

    logic          rd_clk = 1'b0;
    logic          rd_rst = 1'b1;
    logic          fifo_empty;
    logic [FW-1:0] fifo_rd_data;
    logic          fifo_rd_en;
    logic          m_axis_tvalid;
    logic          m_axis_tready = 1'b0;
    logic [FW-2:0] m_axis_tdata;
    logic          m_axis_tlast;
    logic [CW-1:0] pkt_cnt;

    axis_fifo_rd_if #(
        .FIFO_WIDTH (FW),
        .CNT_WIDTH  (CW)
    ) dut (
        .rd_clk        (rd_clk),
        .rd_rst        (rd_rst),
        .fifo_empty    (fifo_empty),
        .fifo_rd_data  (fifo_rd_data),
        .fifo_rd_en    (fifo_rd_en),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tlast  (m_axis_tlast),
        .pkt_cnt       (pkt_cnt)
    );

    always #5 rd_clk = ~rd_clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // FIFO model: word appears on fifo_rd_data the cycle after fifo_rd_en, junk otherwise.
    logic [FW-1:0] fifo_q[$];
    logic [FW-1:0] exp_q[$];
    int unsigned   wr_cnt = 0;
    int unsigned   rd_cnt = 0;
    logic          empty_mask = 1'b0;

    assign fifo_empty = (wr_cnt == rd_cnt) || empty_mask;

    always @(posedge rd_clk) begin
        if (fifo_rd_en && fifo_q.size() != 0) begin
            fifo_rd_data <= fifo_q.pop_front();
            rd_cnt       <= rd_cnt + 1;
        end else begin
            fifo_rd_data <= FW'({$urandom(), $urandom()});
        end
    end

    task automatic push(input logic last, input logic [31:0] d);
        fifo_q.push_back({last, d});
        exp_q.push_back({last, d});
        wr_cnt++;
    endtask

    // Scoreboard and protocol monitor, sampled mid-cycle.
    logic [CW-1:0] exp_pkt   = '0;
    logic          prev_stall = 1'b0;
    logic [FW-1:0] prev_word  = '0;
    logic [FW-1:0] exp_word;

    always @(negedge rd_clk) begin
        check("rd_en_while_empty", 64'(fifo_rd_en && fifo_empty), 64'd0);
        if (rd_rst) exp_pkt = '0;
        check("pkt_cnt", 64'(pkt_cnt), 64'(exp_pkt));
        if (prev_stall && !rd_rst) begin
            check("hold_stable", 64'({m_axis_tvalid, m_axis_tlast, m_axis_tdata}),
                  64'({1'b1, prev_word}));
        end
        prev_stall = m_axis_tvalid && !m_axis_tready && !rd_rst;
        prev_word  = {m_axis_tlast, m_axis_tdata};
        if (m_axis_tvalid && m_axis_tready) begin
            check("beat_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                exp_word = exp_q.pop_front();
                check("beat_word", 64'({m_axis_tlast, m_axis_tdata}), 64'(exp_word));
                if (exp_word[FW-1]) exp_pkt = exp_pkt + 1'b1;
            end
        end
    end

    task automatic next_cycle();
        @(posedge rd_clk);
        #1;
    endtask

    task automatic drain(input string name, input int max_cyc);
        bit done = 1'b0;
        for (int i = 0; i < max_cyc && !done; i++) begin
            @(negedge rd_clk);
            done = (exp_q.size() == 0) && !m_axis_tvalid && !fifo_rd_en;
            next_cycle();
        end
        check(name, 64'(done), 64'd1);
    endtask

    typedef struct {
        logic        tready;
        logic        rd_en;
        logic        tvalid;
        logic [31:0] tdata;
        logic        tlast;
        logic [15:0] pkt;
    } vec_t;

    vec_t vecs[7];
    int   pulses;

    initial begin
        // Four-word packet streamed with tready high; row i is the i-th cycle after reset.
        vecs[0] = '{1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 16'd0};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 16'd0};
        vecs[2] = '{1'b1, 1'b1, 1'b1, 32'h1, 1'b0, 16'd0};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 32'h2, 1'b0, 16'd0};
        vecs[4] = '{1'b1, 1'b0, 1'b1, 32'h3, 1'b0, 16'd0};
        vecs[5] = '{1'b1, 1'b0, 1'b1, 32'h4, 1'b1, 16'd0};
        vecs[6] = '{1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 16'd1};

        for (int i = 1; i <= 4; i++) push(i == 4, 32'(i));

        // Reset held with a non-empty FIFO.
        for (int i = 0; i < 3; i++) begin
            @(negedge rd_clk);
            check("rst_rd_en", 64'(fifo_rd_en), 64'd0);
            check("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
            check("rst_tdata", 64'({m_axis_tlast, m_axis_tdata}), 64'd0);
            check("rst_pkt", 64'(pkt_cnt), 64'd0);
            next_cycle();
        end
        rd_rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            m_axis_tready = vecs[i].tready;
            @(negedge rd_clk);
            check($sformatf("vec%0d_rd_en", i), 64'(fifo_rd_en), 64'(vecs[i].rd_en));
            check($sformatf("vec%0d_tvalid", i), 64'(m_axis_tvalid), 64'(vecs[i].tvalid));
            check($sformatf("vec%0d_pkt", i), 64'(pkt_cnt), 64'(vecs[i].pkt));
            if (vecs[i].tvalid) begin
                check($sformatf("vec%0d_tdata", i), 64'(m_axis_tdata), 64'(vecs[i].tdata));
                check($sformatf("vec%0d_tlast", i), 64'(m_axis_tlast), 64'(vecs[i].tlast));
            end
            next_cycle();
        end
        check("stream_drained", 64'(exp_q.size()), 64'd0);

        // Back-pressure: only two reads may be outstanding while tready is low.
        m_axis_tready = 1'b0;
        for (int i = 0; i < 5; i++) push(i == 4, 32'h10 + 32'(i));
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge rd_clk);
            if (fifo_rd_en) pulses++;
            next_cycle();
        end
        @(negedge rd_clk);
        check("stall_rd_pulses", 64'(pulses), 64'd2);
        check("stall_tvalid", 64'(m_axis_tvalid), 64'd1);
        check("stall_tdata", 64'(m_axis_tdata), 64'h10);
        next_cycle();
        m_axis_tready = 1'b1;
        drain("stall_drain", 50);
        check("stall_pkt", 64'(pkt_cnt), 64'd2);

        // fifo_empty toggling every cycle with random back-pressure.
        for (int i = 0; i < 12; i++) push((i % 4) == 3, 32'h100 + 32'(i));
        for (int i = 0; i < 60; i++) begin
            empty_mask    = ~empty_mask;
            m_axis_tready = 1'($urandom_range(0, 1));
            next_cycle();
        end
        empty_mask    = 1'b0;
        m_axis_tready = 1'b1;
        drain("toggle_drain", 60);
        check("toggle_pkt", 64'(pkt_cnt), 64'd5);

        // Reset pulse with a buffered head and a word in flight.
        m_axis_tready = 1'b0;
        for (int i = 0; i < 6; i++) push(i == 5, 32'h200 + 32'(i));
        repeat (4) next_cycle();
        m_axis_tready = 1'b1;
        next_cycle();
        m_axis_tready = 1'b0;
        rd_rst        = 1'b1;
        exp_q         = fifo_q;
        @(negedge rd_clk);
        check("rstpulse_tvalid_in", 64'(m_axis_tvalid), 64'd0);
        next_cycle();
        rd_rst = 1'b0;
        @(negedge rd_clk);
        check("rstpulse_tvalid_after", 64'(m_axis_tvalid), 64'd0);
        check("rstpulse_rd_en", 64'(fifo_rd_en), 64'd1);
        next_cycle();
        m_axis_tready = 1'b1;
        drain("rstpulse_drain", 50);
        check("rstpulse_pkt", 64'(pkt_cnt), 64'd1);

        // Counter wrap: start from zero, 65535 single-beat packets, then one more.
        rd_rst = 1'b1;
        next_cycle();
        rd_rst = 1'b0;
        for (int i = 0; i < 65535; i++) push(1'b1, 32'(i));
        drain("wrap_fill_drain", 70000);
        check("wrap_pkt_max", 64'(pkt_cnt), 64'hFFFF);
        push(1'b1, 32'hABCD);
        drain("wrap_last_drain", 20);
        check("wrap_pkt_zero", 64'(pkt_cnt), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
